// File: rtl/sensor_pkg.sv
// Shared definitions for the ultrasonic ranger emulator and its host-side core.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package sensor_pkg;

    // Width of every cycle counter and of the programmed echo length.
    localparam int unsigned CNT_W = 32;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Default timing constants, in clk_sys cycles.
    localparam logic [CNT_W-1:0] DEF_MIN_TRIG     = CNT_W'(1000);
    localparam logic [CNT_W-1:0] DEF_BURST_DLY    = CNT_W'(400);
    localparam logic [CNT_W-1:0] DEF_ECHO_TIMEOUT = CNT_W'(1900000);
    localparam logic [CNT_W-1:0] DEF_HOLDOFF      = CNT_W'(1000);

    // Responder state encoding.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TRIG_HI    = 3'd1,
        ST_WAIT_BURST = 3'd2,
        ST_ECHO       = 3'd3,
        ST_HOLDOFF    = 3'd4
    } state_t;

    // Echo length chosen at trigger acceptance: no-target forces the timeout,
    // otherwise the request is clamped into [1, timeout].
    function automatic logic [CNT_W-1:0] clamp_len(
        input logic [CNT_W-1:0] req_len,
        input logic             no_target,
        input logic [CNT_W-1:0] timeout
    );
        logic [CNT_W-1:0] res;
        if (no_target) begin
            res = timeout;
        end else if (req_len == '0) begin
            res = CNT_ONE;
        end else if (req_len > timeout) begin
            res = timeout;
        end else begin
            res = req_len;
        end
        return res;
    endfunction

endpackage

// File: rtl/sensor_edge_sync.sv
// Two-flop synchroniser plus a delay flop giving synced level and edge strobes.
// Latency: level visible 2 edges after the input is sampled; edges valid in that same cycle.
// Backpressure: none; free-running sampler.
module sensor_edge_sync (
    input  logic clk_sys,
    input  logic rst,
    input  logic sig_in,
    output logic sig_s,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;

    // Shift chain: metastability flop, synced flop, one-cycle-old copy for edges.
    always_comb begin
        meta_d = sig_in;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    // Register the chain; all stages clear on reset.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign sig_s = sync_q;
    assign rise  = sync_q & ~dly_q;
    assign fall  = ~sync_q & dly_q;

endmodule

// File: rtl/sensor_echo_gen.sv
// Ultrasonic ranger emulator: validates trig width, waits the burst delay, drives echo for the latched length.
// Latency: echo rises BURST_DLY+1 cycles after the synced trig fall is seen; all outputs registered.
// Backpressure: none; trig edges outside IDLE/TRIG_HI are dropped.
module sensor_echo_gen
    import sensor_pkg::*;
#(
    parameter logic [CNT_W-1:0] MIN_TRIG     = DEF_MIN_TRIG,
    parameter logic [CNT_W-1:0] BURST_DLY    = DEF_BURST_DLY,
    parameter logic [CNT_W-1:0] ECHO_TIMEOUT = DEF_ECHO_TIMEOUT,
    parameter logic [CNT_W-1:0] HOLDOFF      = DEF_HOLDOFF
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             cfg_no_target,
    output logic             echo,
    output logic             echo_busy,
    output logic             echo_done,
    output logic             trig_err
);

    logic trig_s, trig_rise, trig_fall;

    sensor_edge_sync u_trig_sync (
        .clk_sys (clk_sys),
        .rst     (rst),
        .sig_in  (trig),
        .sig_s   (trig_s),
        .rise    (trig_rise),
        .fall    (trig_fall)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] len_q,   len_d;
    logic             echo_q,  echo_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;

    // Next-state logic; the single counter is reused per state (trig width,
    // burst delay, echo length, holdoff).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        echo_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Only a fresh edge starts a trigger, never a level left over from holdoff.
                if (trig_rise) begin
                    state_d = ST_TRIG_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_TRIG_HI: begin
                if (trig_fall) begin
                    if (cnt_q >= MIN_TRIG) begin
                        len_d = clamp_len(cfg_len, cfg_no_target, ECHO_TIMEOUT);
                        if (BURST_DLY == '0) begin
                            state_d = ST_ECHO;
                            echo_d  = 1'b1;
                            cnt_d   = CNT_ONE;
                        end else begin
                            state_d = ST_WAIT_BURST;
                            cnt_d   = '0;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else if (trig_s && (cnt_q < MIN_TRIG)) begin
                    // Saturate at the threshold; long triggers are legal.
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_BURST: begin
                if (cnt_q == BURST_DLY - CNT_ONE) begin
                    state_d = ST_ECHO;
                    echo_d  = 1'b1;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ECHO: begin
                // cnt_q counts echo-high cycles including the current one.
                if (cnt_q >= len_q) begin
                    state_d = ST_HOLDOFF;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    echo_d = 1'b1;
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q >= HOLDOFF) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset forces IDLE with every output low.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            echo_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            echo_q  <= echo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign echo      = echo_q;
    assign echo_busy = (state_q != ST_IDLE);
    assign echo_done = done_q;
    assign trig_err  = err_q;

endmodule

// File: tb/tb_sensor_echo_gen.sv
// Directed bench for the ranger emulator with scaled-down timing constants.
// Latency: expected echo rise is BURST_DLY+3 cycles after the bench drops trig.
// Backpressure: n/a.
module tb_sensor_echo_gen;

    localparam int TB_MIN = 20;
    localparam int TB_BD  = 8;
    localparam int TB_TO  = 300;
    localparam int TB_HO  = 30;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        trig;
    logic [31:0] cfg_len;
    logic        cfg_no_target;
    logic        echo, echo_busy, echo_done, trig_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_sys = ~clk_sys;

    sensor_echo_gen #(
        .MIN_TRIG     (32'd20),
        .BURST_DLY    (32'd8),
        .ECHO_TIMEOUT (32'd300),
        .HOLDOFF      (32'd30)
    ) dut (
        .clk_sys       (clk_sys),
        .rst           (rst),
        .trig          (trig),
        .cfg_len       (cfg_len),
        .cfg_no_target (cfg_no_target),
        .echo          (echo),
        .echo_busy     (echo_busy),
        .echo_done     (echo_done),
        .trig_err      (trig_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold trig high for w cycles; returns in the cycle trig was dropped.
    task automatic send_trig(input int w);
        trig = 1'b1;
        idle(w);
        trig = 1'b0;
    endtask

    // Full accepted transaction: checks rise delay, width, done pulse and busy.
    task automatic do_echo(input string tag, input int w, input logic [31:0] exp_len,
                           input logic chg, input logic [31:0] new_len);
        int k;
        int hi;
        send_trig(w);
        k = 0;
        while (echo !== 1'b1 && k < 200) begin
            step();
            k++;
            if (chg && k == 3) cfg_len = new_len;
        end
        check_val($sformatf("%s_dly", tag), k, TB_BD + 3);
        check_val($sformatf("%s_busy", tag), echo_busy, 1);
        hi = 0;
        while (echo === 1'b1 && hi < 400) begin
            step();
            hi++;
        end
        check_val($sformatf("%s_width", tag), hi, exp_len);
        check_val($sformatf("%s_done", tag), echo_done, 1);
        check_val($sformatf("%s_hold_busy", tag), echo_busy, 1);
        step();
        check_val($sformatf("%s_done_clr", tag), echo_done, 0);
    endtask

    initial begin
        int errc, errk, eh, dc, k;
        rst           = 1'b1;
        trig          = 1'b0;
        cfg_len       = 32'd0;
        cfg_no_target = 1'b0;
        idle(3);
        check_val("rst_echo", echo, 0);
        check_val("rst_busy", echo_busy, 0);
        check_val("rst_done", echo_done, 0);
        check_val("rst_err", trig_err, 0);
        rst = 1'b0;
        idle(5);

        // Nominal trigger.
        cfg_len = 32'd50;
        do_echo("nominal", 30, 32'd50, 1'b0, 32'd0);
        idle(40);

        // Runt trigger one cycle short of the threshold.
        send_trig(TB_MIN - 1);
        errc = 0; errk = 0; eh = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (trig_err === 1'b1) begin errc++; errk = i; end
            if (echo === 1'b1) eh++;
        end
        check_val("runt_err_cnt", errc, 1);
        check_val("runt_err_cyc", errk, 3);
        check_val("runt_no_echo", eh, 0);
        check_val("runt_idle", echo_busy, 0);

        // Exactly the minimum width is accepted.
        cfg_len = 32'd10;
        do_echo("min_trig", TB_MIN, 32'd10, 1'b0, 32'd0);
        idle(40);

        // Length clamps.
        cfg_no_target = 1'b1; cfg_len = 32'd7;
        do_echo("no_target", 25, TB_TO, 1'b0, 32'd0);
        cfg_no_target = 1'b0;
        idle(40);
        cfg_len = 32'hFFFF_FFFF;
        do_echo("len_max", 25, TB_TO, 1'b0, 32'd0);
        idle(40);
        cfg_len = 32'd0;
        do_echo("len_zero", 25, 32'd1, 1'b0, 32'd0);
        idle(40);
        cfg_len = 32'd301;
        do_echo("len_over", 25, TB_TO, 1'b0, 32'd0);
        idle(40);

        // Trigger during holdoff, still high when IDLE is re-entered.
        cfg_len = 32'd20;
        do_echo("pre_hold", 25, 32'd20, 1'b0, 32'd0);
        idle(9);
        send_trig(25);
        eh = 0; errc = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (echo === 1'b1) eh++;
            if (trig_err === 1'b1) errc++;
        end
        check_val("hold_no_echo", eh, 0);
        check_val("hold_no_err", errc, 0);
        check_val("hold_idle", echo_busy, 0);
        do_echo("post_hold", 25, 32'd20, 1'b0, 32'd0);
        idle(40);

        // Reset in the middle of an echo.
        cfg_len = 32'd100;
        send_trig(25);
        k = 0;
        while (echo !== 1'b1 && k < 100) begin step(); k++; end
        check_val("mid_rst_rose", echo, 1);
        idle(40);
        rst = 1'b1;
        step();
        check_val("mid_rst_echo", echo, 0);
        check_val("mid_rst_busy", echo_busy, 0);
        check_val("mid_rst_done", echo_done, 0);
        rst = 1'b0;
        eh = 0; dc = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (echo === 1'b1) eh++;
            if (echo_done === 1'b1) dc++;
        end
        check_val("after_rst_echo", eh, 0);
        check_val("after_rst_done", dc, 0);
        do_echo("after_rst", 25, 32'd100, 1'b0, 32'd0);
        idle(40);

        // cfg_len changed one cycle after the fall is detected.
        cfg_len = 32'd50;
        do_echo("cfg_chg", 25, 32'd50, 1'b1, 32'd10);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
